camera_uart_reporter: RTL and testbench
=======================================

Name: camera_uart_reporter

Overview:
Reports live camera and render state from the FPGA back to a host PC over a UART line, for logging and for scripted camera playback. It sits beside user_control and snapshots its outputs (pos, dir, fractal select, render toggles) either periodically or on request. It serializes each snapshot as a fixed-length, checksummed byte frame in 8N1 format.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 2.
REPORT_PERIOD, 5_000_000, clock cycles between automatic reports (100 ms at 50 MHz); 0 disables periodic reports.
FP_BITS, `FP_BITS, width of one fp component; FP_BYTES = ceil(FP_BITS/8).
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk_in  input  1  system clock (50 MHz)
rst_n_in  input  1  asynchronous active-low reset
pos_in  input  vec3  camera position (user_control pos_out)
dir_in  input  vec3  camera direction (user_control dir_out)
fractal_sel_in  input  3  fractal select
toggles_in  input  4  {hue, color, checker, dither}
enable_in  input  1  gates new frame starts; does not abort a frame in progress
trigger_in  input  1  single-cycle report request
tx_out  output  1  UART line, idle high
busy_out  output  1  high while a frame is being transmitted
frame_count_out  output  16  completed frames, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async assert, sync release): tx_out=1, busy_out=0, frame_count_out=0, period counter=0, pending=0, FSM=IDLE.
- Frame format: SYNC_BYTE; then pos.x, pos.y, pos.z, dir.x, dir.y, dir.z, each sign-extended to FP_BYTES*8 bits, MSB byte first; then status byte = {fractal_sel[2:0], hue, color, checker, dither, 1'b0}; then checksum = XOR of all bytes after SYNC. Length N = 6*FP_BYTES + 3 (21 for FP_BITS=24).
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. Bytes are sent back-to-back with no idle gap after the stop bit.
- Report request: a trigger_in pulse, or the period counter reaching REPORT_PERIOD-1. The period counter is free-running, wraps to 0, and is unaffected by enable_in.
- Start: in IDLE with enable_in=1 and a request (or pending=1), all inputs are latched into a snapshot register in the same cycle. busy_out rises and tx_out drives the start bit on the next cycle (1-cycle latency). Input changes during a frame do not affect it.
- Requests while busy set pending; pending is one-deep and extra requests are merged. Pending starts a new frame in the cycle after the final stop bit, using a fresh snapshot taken in that cycle. Requests while enable_in=0 are dropped and do not set pending.
- Trigger and periodic tick in the same cycle count as one request.
- FSM: IDLE -> LOAD (snapshot, build byte 0) -> SEND (byte index 0..N-1, uart_tx handshake) -> DONE (frame_count++, busy_out=0 unless pending) -> IDLE or LOAD.
- Checksum accumulates byte-by-byte as bytes are handed to uart_tx. The checksum byte itself is excluded.
- Reset mid-frame: tx_out returns to 1 immediately (async) and the frame is abandoned without completion. A truncated byte is acceptable to the host because it resyncs on SYNC_BYTE.

Decomposition:
- Shared package/types.svh: vec3, fp, FP_BITS. Add REPORT_SYNC_BYTE and REPORT_STATUS layout constants so the host decoder and other blocks share them.
- Sub-module uart_tx:
  - inputs: clk_in, rst_n_in, data_in[7:0], valid_in
  - outputs: ready_out, tx_out
  - handshake: byte accepted when valid_in && ready_out; ready_out is low from acceptance until the end of the stop bit.
  - parameter: CLKS_PER_BIT.
- Reporter owns the FSM, snapshot, byte mux, checksum, pending and period counter.

Test Plan:
- Reset value: with rst_n_in=0, then release, and no requests for 1000 cycles -> tx_out=1, busy_out=0, frame_count_out=0 throughout.
- Single frame content: CLKS_PER_BIT=4, FP_BITS=24, REPORT_PERIOD=0, pos.x=24'h123456, all other components 0, fractal_sel=7, toggles=0, one trigger pulse. Required response:
  - tx_out falls 1 cycle after the trigger.
  - Decoded bytes: A5 12 34 56, then 15 bytes of 00, E0, checksum 90.
  - The frame spans 21*10*4=840 cycles, then busy_out falls and frame_count_out=1.
- Snapshot isolation: change pos_in.x to 24'hFFFFFF mid-frame -> the current frame still carries 12 34 56; the next frame carries FF FF FF.
- Pending merge: 3 triggers during one frame -> exactly one extra frame, starting the cycle after the first frame's final stop bit; frame_count_out=2.
- Enable/periodic: REPORT_PERIOD=2000 with enable_in=0 for 5000 cycles -> no frames. Raise enable_in -> a frame starts on the next tick; frames start every 2000 cycles. Dropping enable_in mid-frame still completes that frame.
- Reset mid-frame: assert rst_n_in at byte 5 -> tx_out=1 asynchronously and busy_out=0. After release, a trigger produces a complete, valid frame with frame_count_out=1.

Source files
------------

// File: rtl/camera_uart_reporter_pkg.sv
// Types and constants shared by the camera UART reporter, its UART transmitter and the host decoder.
package camera_uart_reporter_pkg;

    localparam int FP_BITS   = 24;
    localparam int FP_BYTES  = (FP_BITS + 7) / 8;
    localparam int FP_W      = FP_BYTES * 8;
    localparam int FRAME_LEN = 6 * FP_BYTES + 3;
    localparam int PAYLOAD_W = (6 * FP_BYTES + 1) * 8;

    localparam logic [7:0] REPORT_SYNC_BYTE = 8'hA5;

    // Status byte layout: {fractal_sel[2:0], hue, color, checker, dither, 1'b0}
    localparam int REPORT_STATUS_SEL_LSB     = 5;
    localparam int REPORT_STATUS_HUE_BIT     = 4;
    localparam int REPORT_STATUS_COLOR_BIT   = 3;
    localparam int REPORT_STATUS_CHECKER_BIT = 2;
    localparam int REPORT_STATUS_DITHER_BIT  = 1;

    typedef logic signed [FP_BITS-1:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_SEND,
        R_DONE
    } report_state_e;

    function automatic logic [FP_W-1:0] fp_to_wire(input fp v);
        logic signed [FP_W-1:0] w;
        w = v;
        return w;
    endfunction

    function automatic logic [7:0] status_byte(input logic [2:0] sel, input logic [3:0] tog);
        logic [7:0] s;
        s = 8'h00;
        s[REPORT_STATUS_SEL_LSB +: 3]     = sel;
        s[REPORT_STATUS_HUE_BIT]          = tog[3];
        s[REPORT_STATUS_COLOR_BIT]        = tog[2];
        s[REPORT_STATUS_CHECKER_BIT]      = tog[1];
        s[REPORT_STATUS_DITHER_BIT]       = tog[0];
        return s;
    endfunction

endpackage

// File: rtl/camera_uart_reporter_uart_tx.sv
// 8N1 UART transmitter; ready rises in the last stop-bit cycle so bytes can follow with no gap.
module uart_tx
    import camera_uart_reporter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_data;
    logic             r_tx;

    logic w_bit_end;
    logic w_accept;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign ready_out = (r_state == U_IDLE) || ((r_state == U_STOP) && w_bit_end);
    assign w_accept  = valid_in && ready_out;
    assign tx_out    = r_tx;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= U_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else if (w_accept) begin
            r_state <= U_START;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= data_in;
            r_tx    <= 1'b0;
        end else if (r_state != U_IDLE) begin
            if (!w_bit_end) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
                case (r_state)
                    U_START: begin
                        r_state <= U_DATA;
                        r_tx    <= r_data[0];
                    end
                    U_DATA: begin
                        if (r_bit == 3'd7) begin
                            r_state <= U_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            r_data <= {1'b0, r_data[7:1]};
                            r_tx   <= r_data[1];
                        end
                    end
                    default: r_state <= U_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/camera_uart_reporter.sv
// Snapshots camera/render state and streams it to the host as a checksummed UART frame.
module camera_uart_reporter
    import camera_uart_reporter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned REPORT_PERIOD = 5_000_000,
    parameter logic [7:0]  SYNC_BYTE     = REPORT_SYNC_BYTE
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  vec3         pos_in,
    input  vec3         dir_in,
    input  logic [2:0]  fractal_sel_in,
    input  logic [3:0]  toggles_in,
    input  logic        enable_in,
    input  logic        trigger_in,
    output logic        tx_out,
    output logic        busy_out,
    output logic [15:0] frame_count_out
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [31:0] PERIOD_LAST = (REPORT_PERIOD == 0) ? 32'd0 : 32'(REPORT_PERIOD - 1);

    report_state_e        r_state;
    logic [PAYLOAD_W-1:0] r_snap;
    logic [IDX_W-1:0]     r_idx;
    logic [7:0]           r_csum;
    logic                 r_pending;
    logic                 r_busy;
    logic [15:0]          r_frame_cnt;
    logic [31:0]          r_period_cnt;

    logic       w_tick;
    logic       w_req;
    logic       w_tx_ready;
    logic       w_tx_valid;
    logic       w_tx_accept;
    logic       w_launch;
    logic       w_is_csum;
    logic [7:0] w_tx_data;

    function automatic logic [PAYLOAD_W-1:0] build_snapshot(input vec3 p, input vec3 d,
                                                            input logic [2:0] sel,
                                                            input logic [3:0] tog);
        return {fp_to_wire(p.x), fp_to_wire(p.y), fp_to_wire(p.z),
                fp_to_wire(d.x), fp_to_wire(d.y), fp_to_wire(d.z),
                status_byte(sel, tog)};
    endfunction

    assign w_tick = (REPORT_PERIOD != 0) && (r_period_cnt == PERIOD_LAST);
    assign w_req  = trigger_in || w_tick;

    // A frame launches straight from IDLE, or from DONE in the last stop-bit cycle so frames abut.
    assign w_launch = enable_in && (w_req || r_pending) && w_tx_ready &&
                      ((r_state == R_IDLE) || (r_state == R_DONE));

    assign w_is_csum   = (r_idx == IDX_LAST);
    assign w_tx_valid  = w_launch || (r_state == R_SEND);
    assign w_tx_accept = w_tx_valid && w_tx_ready;
    assign w_tx_data   = w_launch  ? SYNC_BYTE :
                         w_is_csum ? r_csum    : r_snap[PAYLOAD_W-1 -: 8];

    assign busy_out        = r_busy;
    assign frame_count_out = r_frame_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= R_IDLE;
            r_snap       <= '0;
            r_idx        <= '0;
            r_csum       <= '0;
            r_pending    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= '0;
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= (r_period_cnt == PERIOD_LAST) ? 32'd0 : r_period_cnt + 32'd1;

            if ((r_state == R_DONE) && w_tx_ready) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            if (w_launch) begin
                r_state   <= R_SEND;
                r_busy    <= 1'b1;
                r_pending <= 1'b0;
                r_idx     <= IDX_FIRST;
                r_csum    <= '0;
                r_snap    <= build_snapshot(pos_in, dir_in, fractal_sel_in, toggles_in);
            end else begin
                case (r_state)
                    R_SEND: begin
                        if (w_req && enable_in) begin
                            r_pending <= 1'b1;
                        end
                        if (w_tx_accept) begin
                            r_idx <= r_idx + 1'b1;
                            if (w_is_csum) begin
                                r_state <= R_DONE;
                            end else begin
                                r_csum <= r_csum ^ w_tx_data;
                                r_snap <= {r_snap[PAYLOAD_W-9:0], 8'h00};
                            end
                        end
                    end
                    R_DONE: begin
                        if (w_tx_ready) begin
                            r_state <= R_IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_req && enable_in) begin
                            r_pending <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .data_in  (w_tx_data),
        .valid_in (w_tx_valid),
        .ready_out(w_tx_ready),
        .tx_out   (tx_out)
    );

endmodule

// File: tb/tb_camera_uart_reporter.sv
// Bench for camera_uart_reporter: UART decode of frames against a byte-level frame model.
`timescale 1ns/1ps
module tb_camera_uart_reporter;
    import camera_uart_reporter_pkg::*;

    localparam int CPB       = 4;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = 21 * BYTE_CYC;
    localparam int PERIOD_B  = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vec3        pos_a, dir_a, pos_b, dir_b;
    logic [2:0] sel_a, sel_b;
    logic [3:0] tog_a, tog_b;
    logic       en_a, trig_a, en_b, trig_b;
    logic       tx_a, busy_a, tx_b, busy_b;
    logic [15:0] fc_a, fc_b;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];

    camera_uart_reporter #(.CLKS_PER_BIT(CPB), .REPORT_PERIOD(0)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .pos_in(pos_a), .dir_in(dir_a),
        .fractal_sel_in(sel_a), .toggles_in(tog_a), .enable_in(en_a), .trigger_in(trig_a),
        .tx_out(tx_a), .busy_out(busy_a), .frame_count_out(fc_a)
    );

    camera_uart_reporter #(.CLKS_PER_BIT(CPB), .REPORT_PERIOD(PERIOD_B)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .pos_in(pos_b), .dir_in(dir_b),
        .fractal_sel_in(sel_b), .toggles_in(tog_b), .enable_in(en_b), .trigger_in(trig_b),
        .tx_out(tx_b), .busy_out(busy_b), .frame_count_out(fc_b)
    );

    // UART receiver on dut_a: samples mid-bit, stores {stop, data}
    logic [7:0] mon_byte;
    always begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx_a === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                mon_byte[k] = tx_a;
            end
            repeat (CPB) @(negedge clk);
            rx_q.push_back({tx_a, mon_byte});
        end
    end

    function automatic void push_frame(input vec3 p, input vec3 d, input logic [2:0] sel,
                                       input logic [3:0] tog);
        logic [23:0] comp [6];
        logic [7:0]  b;
        logic [7:0]  cs;
        comp[0] = p.x; comp[1] = p.y; comp[2] = p.z;
        comp[3] = d.x; comp[4] = d.y; comp[5] = d.z;
        exp_q.push_back({1'b1, 8'hA5});
        cs = 8'h00;
        for (int k = 0; k < 6; k++) begin
            for (int j = 2; j >= 0; j--) begin
                b  = comp[k][j*8 +: 8];
                cs = cs ^ b;
                exp_q.push_back({1'b1, b});
            end
        end
        b  = {sel, tog, 1'b0};
        cs = cs ^ b;
        exp_q.push_back({1'b1, b});
        exp_q.push_back({1'b1, cs});
    endfunction

    task automatic pop_pair(output logic [8:0] e, output logic [8:0] g, output bit have);
        e    = exp_q.pop_front();
        have = (rx_q.size() > 0);
        g    = have ? rx_q.pop_front() : 9'hxxx;
    endtask

    task automatic pulse_a();
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
    endtask

    task automatic wait_level(input bit on_b, input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((on_b ? busy_b : busy_a) === level) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || fc_a !== 16'd0) begin
            errors++;
            $display("FAIL reset_held tx=%b busy=%b fc=%0d want tx=1 busy=0 fc=0", tx_a, busy_a, fc_a);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checks++;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || fc_a !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d tx=%b busy=%b fc=%0d want tx=1 busy=0 fc=0",
                         i, tx_a, busy_a, fc_a);
            end
        end
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_bytes got %0d bytes want 0", rx_q.size());
        end
    endtask

    task automatic test_single_frame();
        logic [8:0] e, g;
        bit have, ok;
        int t0, span, n;
        pos_a = '0; pos_a.x = 24'h123456; dir_a = '0; sel_a = 3'd7; tog_a = 4'd0;
        @(negedge clk);
        checks++;
        if (tx_a !== 1'b1) begin
            errors++;
            $display("FAIL single_pre_idle tx=%b want 1", tx_a);
        end
        push_frame(pos_a, dir_a, sel_a, tog_a);
        pulse_a();
        t0 = cyc;
        checks++;
        if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL single_latency tx=%b busy=%b want tx=0 busy=1", tx_a, busy_a);
        end
        wait_level(1'b0, 1'b0, FRAME_CYC + 100, ok);
        span = cyc - t0;
        checks++;
        if (!ok || span != FRAME_CYC) begin
            errors++;
            $display("FAIL single_span got %0d cycles (done=%0d) want %0d", span, ok, FRAME_CYC);
        end
        checks++;
        if (fc_a !== 16'd1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", fc_a);
        end
        n = 0;
        while (exp_q.size() > 0) begin
            pop_pair(e, g, have);
            checks++;
            if (!have || g !== e) begin
                errors++;
                $display("FAIL single_byte%0d got %h want %h", n, g, e);
            end
            n++;
        end
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL single_extra got %0d extra bytes want 0", rx_q.size());
        end
    endtask

    task automatic test_snapshot();
        logic [8:0] e, g;
        bit have, ok;
        int n;
        pos_a.x = 24'h123456;
        push_frame(pos_a, dir_a, sel_a, tog_a);
        pulse_a();
        repeat (300) @(negedge clk);
        pos_a.x = 24'hFFFFFF;
        wait_level(1'b0, 1'b0, FRAME_CYC, ok);
        checks++;
        if (!ok || fc_a !== 16'd2) begin
            errors++;
            $display("FAIL snap_first_done done=%0d fc=%0d want 1 and 2", ok, fc_a);
        end
        @(negedge clk);
        push_frame(pos_a, dir_a, sel_a, tog_a);
        pulse_a();
        wait_level(1'b0, 1'b0, FRAME_CYC + 10, ok);
        checks++;
        if (!ok || fc_a !== 16'd3) begin
            errors++;
            $display("FAIL snap_second_done done=%0d fc=%0d want 1 and 3", ok, fc_a);
        end
        n = 0;
        while (exp_q.size() > 0) begin
            pop_pair(e, g, have);
            checks++;
            if (!have || g !== e) begin
                errors++;
                $display("FAIL snap_byte%0d got %h want %h", n, g, e);
            end
            n++;
        end
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL snap_extra got %0d extra bytes want 0", rx_q.size());
        end
    endtask

    task automatic test_pending();
        logic [8:0] e, g;
        bit have, ok;
        int t0, span, n;
        pos_a = '0; pos_a.y = 24'h800001; dir_a = '0; dir_a.z = 24'h00ABCD;
        sel_a = 3'd3; tog_a = 4'b1010;
        @(negedge clk);
        push_frame(pos_a, dir_a, sel_a, tog_a);
        push_frame(pos_a, dir_a, sel_a, tog_a);
        pulse_a();
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            repeat (200) @(negedge clk);
            pulse_a();
        end
        wait_level(1'b0, 1'b0, 3 * FRAME_CYC, ok);
        span = cyc - t0;
        checks++;
        if (!ok || span != 2 * FRAME_CYC) begin
            errors++;
            $display("FAIL pending_span got %0d cycles (done=%0d) want %0d", span, ok, 2 * FRAME_CYC);
        end
        checks++;
        if (fc_a !== 16'd5) begin
            errors++;
            $display("FAIL pending_count got %0d want 5", fc_a);
        end
        repeat (FRAME_CYC) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || fc_a !== 16'd5) begin
            errors++;
            $display("FAIL pending_no_third busy=%b fc=%0d want busy=0 fc=5", busy_a, fc_a);
        end
        n = 0;
        while (exp_q.size() > 0) begin
            pop_pair(e, g, have);
            checks++;
            if (!have || g !== e) begin
                errors++;
                $display("FAIL pending_byte%0d got %h want %h", n, g, e);
            end
            n++;
        end
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL pending_extra got %0d extra bytes want 0", rx_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e, g;
        bit have, ok;
        int n;
        pulse_a();
        repeat (5 * BYTE_CYC + 2) @(negedge clk);
        checks++;
        if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre tx=%b busy=%b want tx=0 busy=1", tx_a, busy_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async tx=%b busy=%b want tx=1 busy=0", tx_a, busy_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (fc_a !== 16'd0) begin
            errors++;
            $display("FAIL midrst_count got %0d want 0", fc_a);
        end
        repeat (100) @(negedge clk);
        rx_q.delete();
        exp_q.delete();
        push_frame(pos_a, dir_a, sel_a, tog_a);
        pulse_a();
        wait_level(1'b0, 1'b0, FRAME_CYC + 10, ok);
        checks++;
        if (!ok || fc_a !== 16'd1) begin
            errors++;
            $display("FAIL midrst_after done=%0d fc=%0d want 1 and 1", ok, fc_a);
        end
        n = 0;
        while (exp_q.size() > 0) begin
            pop_pair(e, g, have);
            checks++;
            if (!have || g !== e) begin
                errors++;
                $display("FAIL midrst_byte%0d got %h want %h", n, g, e);
            end
            n++;
        end
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_extra got %0d extra bytes want 0", rx_q.size());
        end
    endtask

    task automatic test_periodic();
        bit ok;
        int busy_seen, t_en, r1, r2, r3;
        busy_seen = 0;
        en_b = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (i == 100) trig_b = 1'b1;
            if (i == 101) trig_b = 1'b0;
            if (busy_b !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || fc_b !== 16'd0) begin
            errors++;
            $display("FAIL periodic_disabled busy_cycles=%0d fc=%0d want 0 and 0", busy_seen, fc_b);
        end
        en_b = 1'b1;
        t_en = cyc;
        wait_level(1'b1, 1'b1, PERIOD_B + 10, ok);
        r1 = cyc;
        checks++;
        if (!ok || (r1 - t_en) > PERIOD_B || tx_b !== 1'b0) begin
            errors++;
            $display("FAIL periodic_first started=%0d after %0d tx=%b want start within %0d tx=0",
                     ok, r1 - t_en, tx_b, PERIOD_B);
        end
        wait_level(1'b1, 1'b0, FRAME_CYC + 10, ok);
        wait_level(1'b1, 1'b1, PERIOD_B + 10, ok);
        r2 = cyc;
        checks++;
        if (!ok || (r2 - r1) != PERIOD_B) begin
            errors++;
            $display("FAIL periodic_interval1 got %0d want %0d", r2 - r1, PERIOD_B);
        end
        wait_level(1'b1, 1'b0, FRAME_CYC + 10, ok);
        wait_level(1'b1, 1'b1, PERIOD_B + 10, ok);
        r3 = cyc;
        checks++;
        if (!ok || (r3 - r2) != PERIOD_B) begin
            errors++;
            $display("FAIL periodic_interval2 got %0d want %0d", r3 - r2, PERIOD_B);
        end
        repeat (100) @(negedge clk);
        en_b = 1'b0;
        wait_level(1'b1, 1'b0, FRAME_CYC, ok);
        checks++;
        if (!ok || (cyc - r3) != FRAME_CYC || fc_b !== 16'd3) begin
            errors++;
            $display("FAIL periodic_disable_mid done=%0d span=%0d fc=%0d want span %0d fc 3",
                     ok, cyc - r3, fc_b, FRAME_CYC);
        end
        busy_seen = 0;
        for (int i = 0; i < 4500; i++) begin
            @(negedge clk);
            if (busy_b !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || fc_b !== 16'd3) begin
            errors++;
            $display("FAIL periodic_stopped busy_cycles=%0d fc=%0d want 0 and 3", busy_seen, fc_b);
        end
    endtask

    initial begin
        pos_a = '0; dir_a = '0; sel_a = '0; tog_a = '0; en_a = 1'b1; trig_a = 1'b0;
        pos_b = '0; dir_b = '0; sel_b = 3'd1; tog_b = 4'hF; en_b = 1'b0; trig_b = 1'b0;
        test_reset();
        test_single_frame();
        test_snapshot();
        test_pending();
        test_reset_mid();
        test_periodic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
